// File: rtl/pc_ctrl_pkg.sv
// Shared state encoding and redirect source codes for the PC redirect controller.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IRQ_DRAIN = 2'd1,
        ST_FLUSH     = 2'd2
    } state_e;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_BRJ  = 2'd1;
    localparam logic [1:0] SRC_IRQ  = 2'd2;
    localparam logic [1:0] SRC_MRET = 2'd3;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Request/redirect bundle between the pipeline (master) and the redirect controller (slave).
interface pc_redirect_ctrl_if;
    logic [31:0] pc_i;
    logic        jump_req_i;
    logic        branch_req_i;
    logic [31:0] target_pc_i;
    logic        mret_req_i;
    logic [31:0] mepc_i;
    logic        irq_pending_i;
    logic        irq_enable_i;
    logic [31:0] interrupt_vector_i;
    logic        pipe_empty_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [1:0]  redirect_src_o;
    logic        flush_o;
    logic        stall_fetch_o;
    logic        irq_ack_o;
    logic        mepc_wr_o;
    logic [31:0] mepc_wdata_o;

    modport master (
        output pc_i, jump_req_i, branch_req_i, target_pc_i, mret_req_i, mepc_i,
               irq_pending_i, irq_enable_i, interrupt_vector_i, pipe_empty_i,
        input  redirect_o, redirect_pc_o, redirect_src_o, flush_o, stall_fetch_o,
               irq_ack_o, mepc_wr_o, mepc_wdata_o
    );

    modport slave (
        input  pc_i, jump_req_i, branch_req_i, target_pc_i, mret_req_i, mepc_i,
               irq_pending_i, irq_enable_i, interrupt_vector_i, pipe_empty_i,
        output redirect_o, redirect_pc_o, redirect_src_o, flush_o, stall_fetch_o,
               irq_ack_o, mepc_wr_o, mepc_wdata_o
    );
endinterface

// File: rtl/pc_flush_timer.sv
// Flush window timer: loaded on a redirect, flush is high for FLUSH_CYCLES enabled cycles after it.
module pc_flush_timer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable,
    input  logic load,
    output logic flush,
    output logic last
);
    logic [3:0] cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt <= 4'd0;
        end else if (enable) begin
            if (load) begin
                cnt <= 4'(FLUSH_CYCLES);
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign flush = (cnt != 4'd0);
    assign last  = (cnt == 4'd1);
endmodule

// File: rtl/pc_redirect_ctrl.sv
// Prioritised PC redirect arbiter with interrupt drain and timed flush window.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned DRAIN_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_design,
    pc_redirect_ctrl_if.slave bus
);
    state_e      state, state_nxt;
    logic [7:0]  drain_cnt;
    logic [31:0] ret_pc;
    logic        ret_dirty;
    logic        active, irq_ok, brj, drain_done, timer_last;
    logic [31:0] eff_ret_pc;
    logic        eff_dirty;
    logic        redirect, ack;
    logic [31:0] redirect_pc;
    logic [1:0]  redirect_src;

    assign active     = enable_design & ~reset_i;
    assign irq_ok     = bus.irq_pending_i & bus.irq_enable_i;
    assign brj        = bus.jump_req_i | bus.branch_req_i;
    assign drain_done = bus.pipe_empty_i | (drain_cnt == 8'(DRAIN_TIMEOUT - 1));
    // A control transfer resolving during the drain is the youngest return point.
    assign eff_ret_pc = brj ? bus.target_pc_i : ret_pc;
    assign eff_dirty  = brj | ret_dirty;

    always_comb begin
        state_nxt    = state;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        redirect_src = SRC_NONE;
        ack          = 1'b0;
        if (active) begin
            case (state)
                ST_RUN: begin
                    if (bus.mret_req_i) begin
                        redirect = 1'b1; redirect_pc = bus.mepc_i; redirect_src = SRC_MRET;
                        state_nxt = ST_FLUSH;
                    end else if (irq_ok) begin
                        state_nxt = ST_IRQ_DRAIN;
                    end else if (brj) begin
                        redirect = 1'b1; redirect_pc = bus.target_pc_i; redirect_src = SRC_BRJ;
                        state_nxt = ST_FLUSH;
                    end
                end
                ST_IRQ_DRAIN: begin
                    if (!irq_ok) begin
                        if (eff_dirty) begin
                            redirect = 1'b1; redirect_pc = eff_ret_pc; redirect_src = SRC_BRJ;
                            state_nxt = ST_FLUSH;
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end else if (drain_done) begin
                        redirect = 1'b1; redirect_pc = bus.interrupt_vector_i; redirect_src = SRC_IRQ;
                        ack = 1'b1;
                        state_nxt = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (timer_last) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= ST_RUN;
            drain_cnt <= 8'd0;
            ret_pc    <= 32'd0;
            ret_dirty <= 1'b0;
        end else if (enable_design) begin
            state <= state_nxt;
            if (state == ST_RUN && !bus.mret_req_i && irq_ok) begin
                ret_pc    <= bus.pc_i;
                ret_dirty <= 1'b0;
                drain_cnt <= 8'd0;
            end else if (state == ST_IRQ_DRAIN && irq_ok && !drain_done) begin
                ret_pc    <= eff_ret_pc;
                ret_dirty <= eff_dirty;
                drain_cnt <= drain_cnt + 8'd1;
            end
        end
    end

    pc_flush_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enable  (enable_design),
        .load    (redirect),
        .flush   (bus.flush_o),
        .last    (timer_last)
    );

    assign bus.redirect_o     = redirect;
    assign bus.redirect_pc_o  = redirect_pc;
    assign bus.redirect_src_o = redirect_src;
    assign bus.irq_ack_o      = ack;
    assign bus.mepc_wr_o      = ack;
    assign bus.mepc_wdata_o   = ack ? eff_ret_pc : 32'd0;
    assign bus.stall_fetch_o  = (state == ST_IRQ_DRAIN);
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboarded bench for pc_redirect_ctrl: directed scenarios then random traffic against a reference model.
module tb_pc_redirect_ctrl;
    localparam int FLUSH_CYCLES  = 2;
    localparam int DRAIN_TIMEOUT = 16;
    localparam int M_RUN = 0, M_DRAIN = 1, M_FLUSH = 2;

    typedef struct {
        logic        rst, en;
        logic [31:0] pc, tgt, mepc, vec;
        logic        jmp, br, mret, irqp, irqe, pe;
    } in_t;
    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic [1:0]  src;
        logic        ack, mwr;
        logic [31:0] mwd;
    } evt_t;
    typedef struct {
        logic flush, stall, evt;
    } st_t;

    logic clk, rst, en;
    pc_redirect_ctrl_if bus();

    pc_redirect_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .enable_design (en),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    evt_t evt_q[$];
    st_t  st_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state: current mode, remaining flush cycles, cycles spent draining.
    int          m_mode = M_RUN;
    int          m_flush = 0;
    int          m_drain = 0;
    logic [31:0] m_ret = 32'd0;
    logic        m_dirty = 1'b0;

    task automatic model_step(input in_t s);
        evt_t        e;
        st_t         t;
        logic        ok, jb, nd;
        logic [31:0] nr;
        e = '{default: 0};
        t = '{default: 0};
        ok = s.irqp & s.irqe;
        jb = s.jmp | s.br;
        nr = jb ? s.tgt : m_ret;
        nd = jb | m_dirty;
        if (s.rst) begin
            m_mode = M_RUN; m_flush = 0; m_drain = 0; m_ret = 0; m_dirty = 0;
        end else begin
            t.flush = (m_mode == M_FLUSH);
            t.stall = (m_mode == M_DRAIN);
            if (s.en) begin
                if (m_mode == M_RUN) begin
                    if (s.mret) begin
                        e.redir = 1; e.rpc = s.mepc; e.src = 2'd3;
                    end else if (ok) begin
                        m_ret = s.pc; m_dirty = 0; m_drain = 0; m_mode = M_DRAIN;
                    end else if (jb) begin
                        e.redir = 1; e.rpc = s.tgt; e.src = 2'd1;
                    end
                end else if (m_mode == M_DRAIN) begin
                    if (!ok) begin
                        if (nd) begin
                            e.redir = 1; e.rpc = nr; e.src = 2'd1;
                        end else begin
                            m_mode = M_RUN;
                        end
                    end else if (s.pe || m_drain == DRAIN_TIMEOUT - 1) begin
                        e.redir = 1; e.rpc = s.vec; e.src = 2'd2;
                        e.ack = 1; e.mwr = 1; e.mwd = nr;
                    end else begin
                        m_ret = nr; m_dirty = nd; m_drain++;
                    end
                end else begin
                    m_flush--;
                    if (m_flush == 0) m_mode = M_RUN;
                end
                if (e.redir) begin
                    m_mode = M_FLUSH; m_flush = FLUSH_CYCLES;
                end
            end
        end
        t.evt = e.redir | e.ack | e.mwr;
        if (t.evt) evt_q.push_back(e);
        st_q.push_back(t);
    endtask

    task automatic cycle(input in_t s);
        @(posedge clk);
        #1;
        rst = s.rst; en = s.en;
        bus.pc_i = s.pc; bus.jump_req_i = s.jmp; bus.branch_req_i = s.br;
        bus.target_pc_i = s.tgt; bus.mret_req_i = s.mret; bus.mepc_i = s.mepc;
        bus.irq_pending_i = s.irqp; bus.irq_enable_i = s.irqe;
        bus.interrupt_vector_i = s.vec; bus.pipe_empty_i = s.pe;
        model_step(s);
    endtask

    function automatic in_t idle();
        in_t s;
        s = '{default: 0};
        s.en = 1; s.pc = 32'h104; s.irqe = 1; s.vec = 32'h80; s.mepc = 32'h108;
        return s;
    endfunction

    // Monitor: per-cycle status always compared; events popped only when the DUT presents one.
    initial begin
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                st_t  t;
                logic dut_evt;
                t = st_q.pop_front();
                dut_evt = bus.redirect_o | bus.irq_ack_o | bus.mepc_wr_o;
                checks++;
                if ({bus.flush_o, bus.stall_fetch_o, dut_evt} !== {t.flush, t.stall, t.evt}) begin
                    failures++;
                    $display("FAIL status t=%0t got flush/stall/evt=%b%b%b want %b%b%b", $time,
                             bus.flush_o, bus.stall_fetch_o, dut_evt, t.flush, t.stall, t.evt);
                end
                if (dut_evt) begin
                    checks++;
                    if (evt_q.size() == 0) begin
                        failures++;
                        $display("FAIL event t=%0t got redirect pc=%h src=%0d with none expected",
                                 $time, bus.redirect_pc_o, bus.redirect_src_o);
                    end else begin
                        evt_t e;
                        e = evt_q.pop_front();
                        if ({bus.redirect_o, bus.redirect_pc_o, bus.redirect_src_o, bus.irq_ack_o,
                             bus.mepc_wr_o, bus.mepc_wdata_o} !== {e.redir, e.rpc, e.src, e.ack, e.mwr, e.mwd}) begin
                            failures++;
                            $display("FAIL event t=%0t got r=%b pc=%h src=%0d ack=%b wr=%b wd=%h want r=%b pc=%h src=%0d ack=%b wr=%b wd=%h",
                                     $time, bus.redirect_o, bus.redirect_pc_o, bus.redirect_src_o,
                                     bus.irq_ack_o, bus.mepc_wr_o, bus.mepc_wdata_o,
                                     e.redir, e.rpc, e.src, e.ack, e.mwr, e.mwd);
                        end
                    end
                end
            end
        end
    end

    initial begin
        in_t  s;
        logic irq_lvl;
        rst = 1; en = 0;
        bus.pc_i = 0; bus.jump_req_i = 0; bus.branch_req_i = 0; bus.target_pc_i = 0;
        bus.mret_req_i = 0; bus.mepc_i = 0; bus.irq_pending_i = 0; bus.irq_enable_i = 0;
        bus.interrupt_vector_i = 0; bus.pipe_empty_i = 0;

        s = idle(); s.rst = 1;
        repeat (2) cycle(s);
        // Branch, then a squashed branch inside the flush window.
        s = idle(); cycle(s);
        s.br = 1; s.tgt = 32'h200; cycle(s);
        s.tgt = 32'h300; cycle(s);
        s = idle(); repeat (3) cycle(s);
        // Interrupt with pipe draining for 3 cycles.
        s.irqp = 1; repeat (4) cycle(s);
        s.pe = 1; cycle(s);
        s = idle(); repeat (3) cycle(s);
        // Jump mid-drain becomes the return address; then same with an irq drop.
        s.irqp = 1; repeat (2) cycle(s);
        s.jmp = 1; s.tgt = 32'h400; cycle(s);
        s.jmp = 0; cycle(s);
        s.pe = 1; cycle(s);
        s = idle(); repeat (3) cycle(s);
        s.irqp = 1; repeat (2) cycle(s);
        s.jmp = 1; s.tgt = 32'h400; cycle(s);
        s.jmp = 0; cycle(s);
        s.irqp = 0; cycle(s);
        s = idle(); repeat (3) cycle(s);
        // mret beats irq; irq is then taken after the flush.
        s.irqp = 1; s.mret = 1; cycle(s);
        s.mret = 0; repeat (4) cycle(s);
        s.pe = 1; cycle(s);
        s = idle(); repeat (3) cycle(s);
        // Drain timeout with pipe never empty.
        s.irqp = 1; repeat (DRAIN_TIMEOUT + 2) cycle(s);
        s = idle(); repeat (3) cycle(s);
        // Reset in the middle of a drain.
        s.irqp = 1; repeat (3) cycle(s);
        s.rst = 1; cycle(s);
        s = idle(); cycle(s);
        // Enable low for 5 cycles inside the flush window.
        s.br = 1; s.tgt = 32'h500; cycle(s);
        s.br = 0; cycle(s);
        s.en = 0; s.br = 1; repeat (5) cycle(s);
        s = idle(); repeat (3) cycle(s);

        irq_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) irq_lvl = ~irq_lvl;
            s.rst  = ($urandom_range(299) == 0);
            s.en   = ($urandom_range(15) != 0);
            s.pc   = $urandom; s.tgt = $urandom; s.mepc = $urandom; s.vec = $urandom;
            s.jmp  = ($urandom_range(7) == 0);
            s.br   = ($urandom_range(7) == 0);
            s.mret = ($urandom_range(15) == 0);
            s.irqp = irq_lvl;
            s.irqe = ($urandom_range(19) != 0);
            s.pe   = ($urandom_range(5) == 0);
            cycle(s);
        end
        s = idle(); repeat (4) cycle(s);
        repeat (2) @(negedge clk);
        checks++;
        if (evt_q.size() != 0 || st_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queues got events=%0d status=%0d left want 0", evt_q.size(), st_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
